// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - branch target resolution with LUT and return-address stack
module branch_ctrl #(
  parameter int T = 10,
  parameter int D = 8,
  parameter int L = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic [T-1:0]           ProgCtr,
  input  logic [2:0]             BrOp,
  input  logic [L-1:0]           BrIdx,
  input  logic                   FlagIn,
  input  logic                   LutWe,
  input  logic [L-1:0]           LutWIdx,
  input  logic [T-1:0]           LutWData,
  output logic                   BranchAbs,
  output logic                   BranchRelEn,
  output logic                   ALU_flag,
  output logic [T-1:0]           Target,
  output logic [$clog2(D+1)-1:0] Depth,
  output logic                   StackErr
);

  localparam int DW = $clog2(D + 1);
  localparam int PW = $clog2(D);

  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_BRU  = 3'd2;
  localparam logic [2:0] OP_BRC  = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4;
  localparam logic [2:0] OP_RET  = 3'd5;

  logic [T-1:0]  lut [2**L];
  logic [T-1:0]  stack [D];
  logic [DW-1:0] depth_q;
  logic          err_q;

  logic          full;
  logic          empty;
  logic [T-1:0]  lut_rd;
  logic [T-1:0]  tos;
  logic          do_push;
  logic          do_pop;
  logic          set_err;

  assign full   = (depth_q == DW'(D));
  assign empty  = (depth_q == '0);
  assign lut_rd = lut[BrIdx];
  // Only meaningful when non-empty; RET guards on empty before using it.
  assign tos    = stack[PW'(depth_q - DW'(1))];

  assign Depth    = depth_q;
  assign StackErr = err_q;

  always_comb begin
    BranchAbs   = 1'b0;
    BranchRelEn = 1'b0;
    ALU_flag    = 1'b0;
    Target      = '0;
    do_push     = 1'b0;
    do_pop      = 1'b0;
    set_err     = 1'b0;
    if (!Reset && !Start) begin
      case (BrOp)
        OP_JMP: begin
          BranchAbs = 1'b1;
          Target    = lut_rd;
        end
        OP_BRU: begin
          BranchRelEn = 1'b1;
          ALU_flag    = 1'b1;
          Target      = ProgCtr + lut_rd;
        end
        OP_BRC: begin
          BranchRelEn = 1'b1;
          ALU_flag    = FlagIn;
          Target      = ProgCtr + lut_rd;
        end
        OP_CALL: begin
          if (!full) begin
            BranchAbs = 1'b1;
            Target    = lut_rd;
            do_push   = 1'b1;
          end else begin
            set_err = 1'b1;
          end
        end
        OP_RET: begin
          if (!empty) begin
            BranchAbs = 1'b1;
            Target    = tos;
            do_pop    = 1'b1;
          end else begin
            set_err = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      depth_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < 2**L; i++) lut[i] <= '0;
    end else begin
      // LUT writes stay live during Start so a program image can be loaded.
      if (LutWe) lut[LutWIdx] <= LutWData;
      if (Start) begin
        depth_q <= '0;
        err_q   <= 1'b0;
      end else begin
        if (do_push) depth_q <= depth_q + DW'(1);
        if (do_pop)  depth_q <= depth_q - DW'(1);
        if (set_err) err_q   <= 1'b1;
      end
    end
  end

  // Stack storage needs no reset: entries above the pointer are never read.
  always_ff @(posedge Clk) begin
    if (do_push) stack[depth_q[PW-1:0]] <= ProgCtr + T'(1);
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - directed and randomized checks of branch_ctrl against a queue model
module tb_branch_ctrl;

  localparam int T = 10;
  localparam int D = 8;
  localparam int L = 4;

  logic         Clk = 1'b0;
  logic         Reset, Start, FlagIn, LutWe;
  logic [T-1:0] ProgCtr, LutWData;
  logic [2:0]   BrOp;
  logic [L-1:0] BrIdx, LutWIdx;
  logic         BranchAbs, BranchRelEn, ALU_flag, StackErr;
  logic [T-1:0] Target;
  logic [3:0]   Depth;

  int errors = 0;
  int checks = 0;

  logic [T-1:0] m_lut [16];
  logic [T-1:0] m_stk [$];
  bit           m_err;

  branch_ctrl #(.T(T), .D(D), .L(L)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgCtr(ProgCtr), .BrOp(BrOp),
    .BrIdx(BrIdx), .FlagIn(FlagIn), .LutWe(LutWe), .LutWIdx(LutWIdx),
    .LutWData(LutWData), .BranchAbs(BranchAbs), .BranchRelEn(BranchRelEn),
    .ALU_flag(ALU_flag), .Target(Target), .Depth(Depth), .StackErr(StackErr)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic st, input logic [2:0] op,
                       input logic [L-1:0] idx, input logic fin, input logic [T-1:0] pc,
                       input logic we, input logic [L-1:0] widx, input logic [T-1:0] wd);
    Reset = rst; Start = st; BrOp = op; BrIdx = idx; FlagIn = fin; ProgCtr = pc;
    LutWe = we; LutWIdx = widx; LutWData = wd;
    #2;
  endtask

  // Expected outputs straight from the opcode rules, using the queue as the stack.
  task automatic check_model(input string tag);
    logic         e_abs, e_rel, e_flag;
    logic [T-1:0] e_tgt;
    e_abs = 0; e_rel = 0; e_flag = 0; e_tgt = 0;
    if (!Reset && !Start) begin
      case (BrOp)
        3'd1: begin e_abs = 1; e_tgt = m_lut[BrIdx]; end
        3'd2: begin e_rel = 1; e_flag = 1; e_tgt = ProgCtr + m_lut[BrIdx]; end
        3'd3: begin e_rel = 1; e_flag = FlagIn; e_tgt = ProgCtr + m_lut[BrIdx]; end
        3'd4: if (m_stk.size() < D) begin e_abs = 1; e_tgt = m_lut[BrIdx]; end
        3'd5: if (m_stk.size() > 0) begin e_abs = 1; e_tgt = m_stk[m_stk.size()-1]; end
        default: ;
      endcase
    end
    chk({tag, ".abs"},   BranchAbs,   e_abs);
    chk({tag, ".rel"},   BranchRelEn, e_rel);
    chk({tag, ".flag"},  ALU_flag,    e_flag);
    chk({tag, ".tgt"},   Target,      e_tgt);
    chk({tag, ".depth"}, Depth,       m_stk.size());
    chk({tag, ".err"},   StackErr,    m_err);
  endtask

  task automatic clk();
    @(posedge Clk);
    if (Reset) begin
      foreach (m_lut[i]) m_lut[i] = 0;
      m_stk.delete();
      m_err = 0;
    end else begin
      if (Start) begin
        m_stk.delete();
        m_err = 0;
      end else if (BrOp == 3'd4) begin
        if (m_stk.size() < D) m_stk.push_back(ProgCtr + 10'd1);
        else m_err = 1;
      end else if (BrOp == 3'd5) begin
        if (m_stk.size() > 0) void'(m_stk.pop_back());
        else m_err = 1;
      end
      if (LutWe) m_lut[LutWIdx] = LutWData;
    end
    #1;
  endtask

  task automatic wr(input logic [L-1:0] idx, input logic [T-1:0] d);
    drive(0, 0, 3'd0, 0, 0, 0, 1, idx, d);
    clk();
  endtask

  initial begin
    foreach (m_lut[i]) m_lut[i] = 'x;
    m_err = 0;
    drive(1, 0, 3'd4, 0, 0, 0, 0, 0, 0);
    clk();
    clk();
    drive(0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
    check_model("reset");
    chk("reset.depth_const", Depth, 0);
    chk("reset.err_const", StackErr, 0);
    clk();

    wr(4'd3, 10'h120);
    drive(0, 0, 3'd1, 4'd3, 0, 10'h000, 0, 0, 0);
    check_model("jmp");
    chk("jmp.tgt_const", Target, 10'h120);
    chk("jmp.abs_const", BranchAbs, 1);
    clk();

    wr(4'd2, 10'h3FC);
    wr(4'd4, 10'h200);
    wr(4'd6, 10'h300);
    drive(0, 0, 3'd3, 4'd2, 0, 10'h002, 0, 0, 0);
    check_model("brc0");
    chk("brc0.tgt_wrap", Target, 10'h3FE);
    chk("brc0.flag", ALU_flag, 0);
    clk();
    drive(0, 0, 3'd3, 4'd2, 1, 10'h002, 0, 0, 0);
    check_model("brc1");
    chk("brc1.flag", ALU_flag, 1);
    clk();
    drive(0, 0, 3'd2, 4'd2, 0, 10'h002, 0, 0, 0);
    check_model("bru");
    clk();

    drive(0, 0, 3'd4, 4'd4, 0, 10'h010, 0, 0, 0);
    check_model("call1");
    chk("call1.tgt", Target, 10'h200);
    clk();
    drive(0, 0, 3'd4, 4'd6, 0, 10'h205, 0, 0, 0);
    check_model("call2");
    chk("call2.depth_before", Depth, 1);
    clk();
    drive(0, 0, 3'd5, 0, 0, 10'h300, 0, 0, 0);
    check_model("ret1");
    chk("ret1.tgt", Target, 10'h206);
    chk("ret1.depth_before", Depth, 2);
    clk();
    drive(0, 0, 3'd5, 0, 0, 10'h206, 0, 0, 0);
    check_model("ret2");
    chk("ret2.tgt", Target, 10'h011);
    clk();
    drive(0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
    chk("ret2.depth_after", Depth, 0);

    for (int i = 0; i <= D; i++) begin
      drive(0, 0, 3'd4, 4'd4, 0, 10'h040 + 10'(i), 0, 0, 0);
      check_model("ovf_call");
      chk("ovf_call.abs", BranchAbs, (i < D) ? 1 : 0);
      clk();
    end
    drive(0, 0, 3'd5, 0, 0, 0, 0, 0, 0);
    chk("ovf.err", StackErr, 1);
    chk("ovf.depth", Depth, D);
    chk("ovf.ret_tgt", Target, 10'h048);
    check_model("ovf_ret");
    clk();

    drive(0, 1, 3'd1, 4'd3, 0, 0, 0, 0, 0);
    check_model("start_outs");
    chk("start.abs_zero", BranchAbs, 0);
    clk();
    drive(0, 0, 3'd5, 0, 0, 10'h0AB, 0, 0, 0);
    check_model("udf");
    chk("udf.err_before", StackErr, 0);
    chk("udf.abs", BranchAbs, 0);
    clk();
    drive(0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
    chk("udf.err", StackErr, 1);
    clk();
    drive(0, 1, 3'd0, 0, 0, 0, 0, 0, 0);
    clk();
    drive(0, 0, 3'd1, 4'd3, 0, 0, 0, 0, 0);
    check_model("after_start");
    chk("start.err_clr", StackErr, 0);
    chk("start.lut_kept", Target, 10'h120);
    clk();

    wr(4'd5, 10'h155);
    drive(0, 0, 3'd1, 4'd5, 0, 0, 1, 4'd5, 10'h0AA);
    check_model("rdw");
    chk("rdw.old", Target, 10'h155);
    clk();
    drive(0, 0, 3'd1, 4'd5, 0, 0, 0, 0, 0);
    check_model("rdw_next");
    chk("rdw.new", Target, 10'h0AA);
    clk();

    drive(0, 0, 3'd4, 4'd4, 0, 10'h100, 0, 0, 0);
    clk();
    drive(1, 0, 3'd4, 4'd4, 0, 10'h101, 0, 0, 0);
    check_model("rst_call");
    clk();
    drive(0, 0, 3'd1, 4'd3, 0, 0, 0, 0, 0);
    check_model("post_rst");
    chk("post_rst.depth", Depth, 0);
    chk("post_rst.lut3", Target, 0);
    clk();
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 3'd1, 4'(i), 0, 0, 0, 0, 0);
      chk("post_rst.lut_all", Target, 0);
      clk();
    end

    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 49) == 0),
            3'($urandom_range(0, 7)), 4'($urandom), 1'($urandom), 10'($urandom),
            ($urandom_range(0, 3) == 0), 4'($urandom), 10'($urandom));
      check_model("rand");
      clk();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
